game_tick_scheduler: RTL

- Programmable game-step tick generator and run-state controller for the goose-run core.
- Replaces fixed-rate tick division: sequences the step period from a difficulty level, handles start/pause/stop, and ramps speed as play continues.
- Output tick strobe drives the game-state update logic; level and tick_total feed the display/score path.

---
 rtl/game_tick_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/game_tick_scheduler.sv
// ---------------------------------------------------------------------------
// game_tick_scheduler
//
// Game-step tick generator and run-state controller for the goose-run core.
// A period counter produces a one-cycle tick per game step; the step period
// shrinks as the difficulty level rises. A small IDLE/RUN/PAUSE state
// machine handles start, pause and stop (game over).
//
// Optional feature macro: DIFFICULTY_RAMP_EN
//   defined   - level advances every LEVEL_TICKS ticks up to MAX_LEVEL and
//               each level shortens the period by PERIOD_STEP.
//   undefined - level is tied to 0 and the period is fixed at BASE_PERIOD.
//
// Ports:
//   clk_in      in   system clock
//   rst         in   asynchronous active-high reset
//   start       in   1-cycle pulse: begin or restart a run
//   pause_req   in   level: hold the run while high
//   stop        in   1-cycle pulse: end the run (game over)
//   tick_out    out  registered 1-cycle game-step strobe
//   level       out  current difficulty level (held in IDLE for display)
//   running     out  high in RUN or PAUSE
//   paused      out  high in PAUSE
//   tick_total  out  ticks since last start, saturating at 65535
// ---------------------------------------------------------------------------
module game_tick_scheduler #(
    parameter int BASE_PERIOD = 40000000,
    parameter int PERIOD_STEP = 4000000,
    parameter int MAX_LEVEL   = 7,
    parameter int LEVEL_TICKS = 20,
    parameter int CNT_W       = 28
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic        pause_req,
    input  logic        stop,
    output logic        tick_out,
    output logic [2:0]  level,
    output logic        running,
    output logic        paused,
    output logic [15:0] tick_total
);

    // A configuration that would make the shortest period non-positive, a
    // level that does not fit the 3-bit port, or a counter too narrow for
    // BASE_PERIOD-1 keeps the scheduler idle instead of ticking at a bogus
    // rate.
    localparam bit CFG_OK = (BASE_PERIOD > MAX_LEVEL * PERIOD_STEP) &&
                            (MAX_LEVEL >= 0) && (MAX_LEVEL <= 7) &&
                            (LEVEL_TICKS >= 1) &&
                            (((BASE_PERIOD - 1) >> CNT_W) == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              restart;
    logic              advance;
    logic              wrap;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  period_m1;
    logic              tick_nxt;
    logic [15:0]       total_nxt;

    // Last counter value of a step at the given level: period(level) - 1.
    function automatic logic [CNT_W-1:0] period_last(input logic [2:0] lvl);
        int p;
        p = BASE_PERIOD - 1 - int'(lvl) * PERIOD_STEP;
        return CNT_W'(p);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- state register ----
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state decode; priority stop > start > pause_req ----
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop && CFG_OK) begin
                    state_nxt = ST_RUN;
                    restart   = 1'b1;
                end
            end
            ST_RUN, ST_PAUSE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt = ST_RUN;
                    restart   = 1'b1;
                end else if (pause_req) begin
                    state_nxt = ST_PAUSE;
                end else begin
                    // Leaving PAUSE counts in the same cycle, so a pause of
                    // N cycles delays the next tick by exactly N.
                    state_nxt = ST_RUN;
                    advance   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign period_m1 = period_last(level);
    assign wrap      = advance && (cnt_q == period_m1);

    // ---- counter / tick / total next values ----
    always_comb begin
        cnt_nxt   = cnt_q;
        tick_nxt  = 1'b0;
        total_nxt = tick_total;
        if (restart) begin
            cnt_nxt   = '0;
            total_nxt = 16'd0;
        end else if (state_nxt == ST_IDLE) begin
            cnt_nxt = '0;
        end else if (wrap) begin
            cnt_nxt   = '0;
            tick_nxt  = 1'b1;
            total_nxt = sat_inc16(tick_total);
        end else if (advance) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    // ---- register stage: counter, tick strobe, total ----
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            tick_out   <= 1'b0;
            tick_total <= 16'd0;
        end else begin
            cnt_q      <= cnt_nxt;
            tick_out   <= tick_nxt;
            tick_total <= total_nxt;
        end
    end

`ifdef DIFFICULTY_RAMP_EN
    localparam int LT_W = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;

    logic [2:0]      level_q;
    logic [2:0]      level_nxt;
    logic [LT_W-1:0] lt_q;
    logic [LT_W-1:0] lt_nxt;

    // Level advances on the tick that completes LEVEL_TICKS ticks; the
    // counter is already 0 then, so the shorter period applies at once.
    // At MAX_LEVEL both level and level_ticks stop moving.
    always_comb begin
        level_nxt = level_q;
        lt_nxt    = lt_q;
        if (restart) begin
            level_nxt = 3'd0;
            lt_nxt    = '0;
        end else if (wrap && (level_q < 3'(MAX_LEVEL))) begin
            if (lt_q == LT_W'(LEVEL_TICKS - 1)) begin
                level_nxt = level_q + 3'd1;
                lt_nxt    = '0;
            end else begin
                lt_nxt = lt_q + LT_W'(1);
            end
        end
    end

    // ---- register stage: difficulty level ----
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            level_q <= 3'd0;
            lt_q    <= '0;
        end else begin
            level_q <= level_nxt;
            lt_q    <= lt_nxt;
        end
    end

    assign level = level_q;
`else
    assign level = 3'd0;
`endif

    assign running = (state != ST_IDLE);
    assign paused  = (state == ST_PAUSE);

endmodule
